// File: rtl/vga_timing_generator.sv
// 800x600 raster timing generator: look-ahead pixel counters plus LATENCY-delayed blank/sync.
// Optional frame counter and vblank flag when VGA_TIMING_FRAME_COUNT_EN is defined.
module vga_timing_generator #(
  parameter int unsigned H_ACTIVE         = 800,
  parameter int unsigned H_FRONT          = 56,
  parameter int unsigned H_SYNC           = 120,
  parameter int unsigned H_BACK           = 64,
  parameter int unsigned V_ACTIVE         = 600,
  parameter int unsigned V_FRONT          = 37,
  parameter int unsigned V_SYNC           = 6,
  parameter int unsigned V_BACK           = 23,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b1,
  parameter int unsigned LATENCY          = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [10:0] nextX,
  output logic [9:0]  nextY,
  output logic        blank_n,
  output logic        sync_n,
  output logic        hSync_n,
  output logic        vSync_n,
  output logic        lineStart,
  output logic        frameStart
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0] frameCount,
  output logic        inVblank
`endif
);

  localparam int unsigned XW      = 11;
  localparam int unsigned YW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SY_AT = H_ACTIVE + H_FRONT;
  localparam int unsigned H_BP_AT = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int unsigned V_SY_AT = V_ACTIVE + V_FRONT;
  localparam int unsigned V_BP_AT = V_ACTIVE + V_FRONT + V_SYNC;
  localparam logic        SYNC_ON = 1'(SYNC_ACTIVE_HIGH);

  if (H_TOTAL > 2048) begin : g_bad_h_total
    $error("vga_timing_generator: H_total exceeds 11-bit counter range");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_generator: V_total exceeds 10-bit counter range");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("vga_timing_generator: LATENCY must be 1..4");
  end

  typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_e;

  h_state_e          h_state_q;
  v_state_e          v_state_q;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              h_wrap, v_wrap;
  logic              visible, hs_lvl, vs_lvl;
  logic [LATENCY-1:0] vis_sr_q, hs_sr_q, vs_sr_q;
  logic              line_start_q, frame_start_q;

  // Next counter values; the vertical counter only moves on the horizontal wrap.
  always_comb begin
    h_wrap = (x_q == XW'(H_TOTAL - 1));
    v_wrap = (y_q == YW'(V_TOTAL - 1));
    x_d    = h_wrap ? '0 : x_q + XW'(1);
    y_d    = y_q;
    if (h_wrap) begin
      y_d = v_wrap ? '0 : y_q + YW'(1);
    end
  end

  // Undelayed raster flags derived from the state of the current (nextX, nextY).
  always_comb begin
    visible = (h_state_q == H_ACT) && (v_state_q == V_ACT);
    hs_lvl  = (h_state_q == H_SY) ? SYNC_ON : ~SYNC_ON;
    vs_lvl  = (v_state_q == V_SY) ? SYNC_ON : ~SYNC_ON;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      x_q           <= '0;
      y_q           <= '0;
      h_state_q     <= H_ACT;
      v_state_q     <= V_ACT;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vis_sr_q      <= '0;
      hs_sr_q       <= {LATENCY{~SYNC_ON}};
      vs_sr_q       <= {LATENCY{~SYNC_ON}};
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
      // Shift registers grow toward the MSB, which drives the pins.
      vis_sr_q      <= LATENCY'({vis_sr_q, visible});
      hs_sr_q       <= LATENCY'({hs_sr_q, hs_lvl});
      vs_sr_q       <= LATENCY'({vs_sr_q, vs_lvl});

      unique case (h_state_q)
        H_ACT:   if (x_d == XW'(H_ACTIVE)) h_state_q <= H_FP;
        H_FP:    if (x_d == XW'(H_SY_AT))  h_state_q <= H_SY;
        H_SY:    if (x_d == XW'(H_BP_AT))  h_state_q <= H_BP;
        H_BP:    if (x_d == '0)            h_state_q <= H_ACT;
        default: h_state_q <= H_ACT;
      endcase

      if (h_wrap) begin
        unique case (v_state_q)
          V_ACT:   if (y_d == YW'(V_ACTIVE)) v_state_q <= V_FP;
          V_FP:    if (y_d == YW'(V_SY_AT))  v_state_q <= V_SY;
          V_SY:    if (y_d == YW'(V_BP_AT))  v_state_q <= V_BP;
          V_BP:    if (y_d == '0)            v_state_q <= V_ACT;
          default: v_state_q <= V_ACT;
        endcase
      end
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  // Counts frame starts; wraps naturally at 16 bits.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      frame_cnt_q <= '0;
    end else if (h_wrap && v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frameCount = frame_cnt_q;
  assign inVblank   = (v_state_q != V_ACT);
`endif

  assign nextX      = x_q;
  assign nextY      = y_q;
  assign blank_n    = vis_sr_q[LATENCY-1];
  assign hSync_n    = hs_sr_q[LATENCY-1];
  assign vSync_n    = vs_sr_q[LATENCY-1];
  assign sync_n     = 1'b1;
  assign lineStart  = line_start_q;
  assign frameStart = frame_start_q;

endmodule
